ex_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, operating beside the single-cycle ALU on the same src_a/src_b operands.
- Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and owns the architectural HI/LO registers.
- MTHI/MTLO write HI/LO directly.
- Raises stall_req so the pipeline freezes until results are committed; later stages read HI/LO for MFHI/MFLO.

---
 rtl/ex_muldiv_pkg.sv | 38 +++
 rtl/md_abs_neg.sv | 15 +
 rtl/ex_muldiv.sv | 174 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit: op codes, FSM states, iteration count.
// Pure declarations, no logic; imported by ex_muldiv.
package ex_muldiv_pkg;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = $clog2(MD_ITER);

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } md_state_t;

  // Ops that occupy the unit for the full iterative sequence.
  function automatic logic md_is_iter(md_op_t op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  function automatic logic md_is_signed(md_op_t op);
    return op inside {MD_MULT, MD_DIV};
  endfunction

  function automatic logic md_is_div(md_op_t op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/md_abs_neg.sv
// Conditional two's-complement negate: res = neg ? -val : val. Combinational, zero latency.
// Used both for operand magnitudes (neg = sign bit) and for result sign correction.
module md_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  always_comb begin
    res = neg ? (~val + W'(1)) : val;
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU (one bit per cycle) owning HI/LO; MTHI/MTLO write in one cycle.
// Latency: accept T, PREP T+1, CALC T+2..T+33, FIX T+34; stall_req holds the pipeline until FIX ends.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              md_valid,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  md_state_t             state, state_nxt;
  md_op_t                op_in, op_q;
  logic [DATA_W-1:0]     a_q, b_q, mag_op;
  logic [2*DATA_W-1:0]   acc;
  logic [MD_CNT_W-1:0]   cnt;
  logic                  res_neg, dvd_neg;
  logic [DATA_W-1:0]     hi_q, lo_q;
  logic                  accept;

  logic [DATA_W-1:0]     mag_a, mag_b;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quot_fix, rem_fix;
  logic [DATA_W:0]       mul_sum, rem_sh, trial;
  logic [2*DATA_W-1:0]   mul_nxt, div_nxt, fix_res;

  assign op_in  = md_op_t'(md_op);
  assign accept = (state == IDLE) && md_valid && !flush;
  assign hi     = hi_q;
  assign lo     = lo_q;

  md_abs_neg #(.W(DATA_W)) u_abs_a (
    .val (a_q),
    .neg (md_is_signed(op_q) && a_q[DATA_W-1]),
    .res (mag_a)
  );

  md_abs_neg #(.W(DATA_W)) u_abs_b (
    .val (b_q),
    .neg (md_is_signed(op_q) && b_q[DATA_W-1]),
    .res (mag_b)
  );

  md_abs_neg #(.W(2*DATA_W)) u_fix_prod (
    .val (acc),
    .neg (res_neg),
    .res (prod_fix)
  );

  md_abs_neg #(.W(DATA_W)) u_fix_quot (
    .val (acc[DATA_W-1:0]),
    .neg (res_neg),
    .res (quot_fix)
  );

  md_abs_neg #(.W(DATA_W)) u_fix_rem (
    .val (acc[2*DATA_W-1:DATA_W]),
    .neg (dvd_neg),
    .res (rem_fix)
  );

  // Shift-add multiply: the 33-bit sum keeps the carry, which shifts into the top bit.
  always_comb begin
    mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, mag_op};
    mul_nxt = acc[0] ? {mul_sum, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W-1:1]};
  end

  // Restoring divide: the shifted remainder is < 2*divisor, so bit DATA_W of trial is its sign.
  always_comb begin
    rem_sh  = acc[2*DATA_W-1:DATA_W-1];
    trial   = rem_sh - {1'b0, mag_op};
    div_nxt = trial[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0}
                            : {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
  end

  always_comb begin
    if (!md_is_div(op_q))
      fix_res = prod_fix;
    else if (b_q == '0)
      fix_res = {a_q, {DATA_W{1'b1}}};
    else
      fix_res = {rem_fix, quot_fix};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && md_is_iter(op_in)) state_nxt = PREP;
      PREP:    state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush && state != IDLE)
      state_nxt = IDLE;
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIX) && !flush;
    stall_req = busy || (md_valid && !flush && md_is_iter(op_in));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      mag_op  <= '0;
      acc     <= '0;
      cnt     <= '0;
      res_neg <= 1'b0;
      dvd_neg <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_in)
              MD_MTHI: hi_q <= src_a;
              MD_MTLO: lo_q <= src_a;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                op_q <= op_in;
                a_q  <= src_a;
                b_q  <= src_b;
              end
              default: ;
            endcase
          end
        end
        PREP: begin
          res_neg <= md_is_signed(op_q) && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
          dvd_neg <= md_is_signed(op_q) && a_q[DATA_W-1];
          cnt     <= MD_CNT_W'(MD_ITER - 1);
          if (md_is_div(op_q)) begin
            acc    <= {{DATA_W{1'b0}}, mag_a};
            mag_op <= mag_b;
          end else begin
            acc    <= {{DATA_W{1'b0}}, mag_b};
            mag_op <= mag_a;
          end
        end
        CALC: begin
          acc <= md_is_div(op_q) ? div_nxt : mul_nxt;
          cnt <= cnt - MD_CNT_W'(1);
        end
        FIX: begin
          if (!flush)
            {hi_q, lo_q} <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized self-checking bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        md_valid = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        flush = 1'b0;
  logic        busy, stall_req, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst_n), .md_valid(md_valid), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {hi,lo} from plain arithmetic.
  function automatic logic [63:0] ref_calc(md_op_t op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Model: m_cyc counts remaining busy cycles (34 after acceptance, 1 = FIX).
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_cyc <= 0; p_hi <= '0; p_lo <= '0;
    end else if (m_cyc == 0) begin
      if (md_valid && !flush) begin
        case (md_op_t'(md_op))
          MD_MTHI: m_hi <= src_a;
          MD_MTLO: m_lo <= src_a;
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            {p_hi, p_lo} <= ref_calc(md_op_t'(md_op), src_a, src_b);
            m_cyc <= 34;
          end
          default: ;
        endcase
      end
    end else if (flush) begin
      m_cyc <= 0;
    end else begin
      if (m_cyc == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
      m_cyc <= m_cyc - 1;
    end
  end

  always @(negedge clk) begin
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    chk("busy", 64'(busy), 64'(m_cyc != 0));
    chk("done", 64'(done), 64'(m_cyc == 1 && !flush));
    chk("stall_req", 64'(stall_req),
        64'((m_cyc != 0) || (md_valid && !flush && md_is_iter(md_op_t'(md_op)))));
  end

  // Drives one request and follows it until stall_req falls; flush_at is a cycle index (-1 = never).
  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int stall_cnt, output int done_idx);
    int idx;
    idx = 0;
    stall_cnt = 0;
    done_idx = -1;
    @(posedge clk); #2;
    while (1) begin
      md_valid = (idx == 0);
      md_op    = op;
      src_a    = a;
      src_b    = b;
      flush    = (idx == flush_at);
      #1;
      if (stall_req) stall_cnt++;
      if (done) done_idx = idx;
      if (idx > 0 && !stall_req) break;
      if (idx >= 60) begin
        n_cmp++;
        n_bad++;
        $display("FAIL op_timeout: stall_req still %0b after %0d cycles", stall_req, idx);
        break;
      end
      idx++;
      @(posedge clk); #2;
    end
    md_valid = 1'b0;
    flush    = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, di, fa;
    md_op_t rop;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, -1, sc, di);
    chk("mult_stall_cycles", 64'(sc), 64'd35);
    chk("mult_done_idx", 64'(di), 64'd34);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, sc, di);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(MD_DIVU, 32'd100, 32'd7, -1, sc, di);
    chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, sc, di);
    chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, -1, sc, di);
    chk("div_7_m2", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, sc, di);
    chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(MD_DIVU, 32'd5, 32'd0, -1, sc, di);
    chk("divu_by_zero", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    chk("divu_by_zero_done_idx", 64'(di), 64'd34);

    @(posedge clk); #2;
    md_valid = 1'b1; md_op = MD_MTHI; src_a = 32'h1234;
    #1 chk("mthi_stall", 64'(stall_req), 64'h0);
    @(posedge clk); #2;
    md_op = MD_MTLO; src_a = 32'h5678;
    #1 chk("mtlo_busy", 64'(busy), 64'h0);
    @(posedge clk); #2;
    md_valid = 1'b0;
    #1;
    chk("mthi_mtlo", {hi, lo}, 64'h0000_1234_0000_5678);

    run_op(MD_DIV, 32'd100, 32'd7, 10, sc, di);
    chk("flush_stall_cycles", 64'(sc), 64'd11);
    chk("flush_no_done", 64'(di), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("flush_keeps_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    run_op(MD_MULT, 32'd3, 32'd4, 0, sc, di);
    chk("flush_at_accept_stall", 64'(sc), 64'd0);
    chk("flush_at_accept_hilo", {hi, lo}, 64'h0000_1234_0000_5678);

    @(posedge clk); #2;
    md_valid = 1'b1; md_op = MD_MULT; src_a = 32'd5; src_b = 32'd6; flush = 1'b0;
    repeat (20) begin
      @(posedge clk); #2;
      md_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'h0);
    chk("async_rst_hilo", {hi, lo}, 64'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_op(MD_DIVU, 32'd9, 32'd3, -1, sc, di);
    chk("divu_after_rst", {hi, lo}, {32'd0, 32'd3});

    for (int i = 0; i < 40; i++) begin
      rop = md_op_t'(3'($urandom_range(0, 6)));
      fa  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 36)) : -1;
      run_op(rop, pick(), pick(), fa, sc, di);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
